// File: rtl/mem_read_arbiter_if.sv
// ============================================================================
//  mem_read_arbiter_if : requester, memory and status bundle of mem_read_arbiter
//  Revision 1.0
// ============================================================================
`default_nettype none

interface mem_read_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32
);
   logic              i_icache_req;
   logic [ADDR_W-1:0] i_icache_addr;
   logic              i_dcache_req;
   logic [ADDR_W-1:0] i_dcache_addr;
   logic              o_icache_gnt;
   logic              o_dcache_gnt;
   logic              o_icache_r_valid;
   logic              o_icache_r_last;
   logic              o_dcache_r_valid;
   logic              o_dcache_r_last;
   logic [DATA_W-1:0] o_r_data;
   logic              o_mem_req;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              i_mem_r_valid;
   logic              i_mem_r_last;
   logic [DATA_W-1:0] i_mem_r_data;
   logic              o_burst_err;

   // Arbiter side
   modport slave (
      input  i_icache_req, i_icache_addr, i_dcache_req, i_dcache_addr,
      input  i_mem_r_valid, i_mem_r_last, i_mem_r_data,
      output o_icache_gnt, o_dcache_gnt,
      output o_icache_r_valid, o_icache_r_last, o_dcache_r_valid, o_dcache_r_last,
      output o_r_data, o_mem_req, o_mem_addr, o_burst_err
   );

   // Requesters and memory side
   modport master (
      output i_icache_req, i_icache_addr, i_dcache_req, i_dcache_addr,
      output i_mem_r_valid, i_mem_r_last, i_mem_r_data,
      input  o_icache_gnt, o_dcache_gnt,
      input  o_icache_r_valid, o_icache_r_last, o_dcache_r_valid, o_dcache_r_last,
      input  o_r_data, o_mem_req, o_mem_addr, o_burst_err
   );
endinterface

`default_nettype wire

// File: rtl/mem_read_arbiter.sv
// ============================================================================
//  mem_read_arbiter : two-requester (icache/dcache) burst read arbiter.
//  Tie-break: round-robin when MEM_ARB_ROUND_ROBIN_EN is defined, else dcache.
//  Revision 1.0
// ============================================================================
`default_nettype none

module mem_read_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32,
   parameter int BEATS  = 16
) (
   input  wire logic           clk,
   input  wire logic           arst,
   mem_read_arbiter_if.slave   bus
);

   localparam int              CNT_W    = (BEATS > 2) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t            state;
   logic              icache_gnt;
   logic              dcache_gnt;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [CNT_W-1:0]  beat_cnt;
   logic              burst_err;

   logic              pick_d;
   logic              any_req;
   logic              beat_bad;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Set when dcache owned the most recent burst
   logic              last_d;

   always_comb begin
      pick_d = bus.i_dcache_req & (~bus.i_icache_req | ~last_d);
   end
`else
   always_comb begin
      pick_d = bus.i_dcache_req;
   end
`endif

   always_comb begin
      any_req  = bus.i_icache_req | bus.i_dcache_req;
      beat_bad = ( bus.i_mem_r_last & (beat_cnt != LAST_CNT)) |
                 (~bus.i_mem_r_last & (beat_cnt == LAST_CNT));
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state      <= IDLE;
         icache_gnt <= 1'b0;
         dcache_gnt <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         beat_cnt   <= '0;
         burst_err  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_d     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  mem_req  <= 1'b1;
                  beat_cnt <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_d   <= pick_d;
`endif
                  if (pick_d) begin
                     state      <= GRANT_D;
                     dcache_gnt <= 1'b1;
                     mem_addr   <= bus.i_dcache_addr;
                  end else begin
                     state      <= GRANT_I;
                     icache_gnt <= 1'b1;
                     mem_addr   <= bus.i_icache_addr;
                  end
               end
            end

            GRANT_I, GRANT_D: begin
               // Requests are not looked at here: the grant holds until r_last
               if (bus.i_mem_r_valid) begin
                  beat_cnt <= beat_cnt + CNT_ONE;
                  if (beat_bad) begin
                     burst_err <= 1'b1;
                  end
                  if (bus.i_mem_r_last) begin
                     state      <= IDLE;
                     icache_gnt <= 1'b0;
                     dcache_gnt <= 1'b0;
                     mem_req    <= 1'b0;
                  end
               end
            end

            default: begin
               state      <= IDLE;
               icache_gnt <= 1'b0;
               dcache_gnt <= 1'b0;
               mem_req    <= 1'b0;
            end
         endcase
      end
   end

   // Beat routing is combinational so memory beats reach the owner with no delay
   assign bus.o_icache_r_valid = icache_gnt & bus.i_mem_r_valid;
   assign bus.o_icache_r_last  = icache_gnt & bus.i_mem_r_valid & bus.i_mem_r_last;
   assign bus.o_dcache_r_valid = dcache_gnt & bus.i_mem_r_valid;
   assign bus.o_dcache_r_last  = dcache_gnt & bus.i_mem_r_valid & bus.i_mem_r_last;
   assign bus.o_r_data         = bus.i_mem_r_data;
   assign bus.o_icache_gnt     = icache_gnt;
   assign bus.o_dcache_gnt     = dcache_gnt;
   assign bus.o_mem_req        = mem_req;
   assign bus.o_mem_addr       = mem_addr;
   assign bus.o_burst_err      = burst_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
// ============================================================================
//  tb_mem_read_arbiter : directed self-checking bench for mem_read_arbiter
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_read_arbiter;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 32;
   localparam int BEATS  = 16;

   logic clk;
   logic arst;
   int   n_cmp;
   int   n_mis;
   int   ilast_seen;
   int   dlast_seen;

   mem_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_value({tag, "_igant"}, 64'(bus.o_icache_gnt), 64'd0);
      check_value({tag, "_dgnt"},  64'(bus.o_dcache_gnt), 64'd0);
      check_value({tag, "_mreq"},  64'(bus.o_mem_req),    64'd0);
   endtask

   task automatic check_grant(input string tag, input int owner, input logic [63:0] addr);
      check_value({tag, "_igant"}, 64'(bus.o_icache_gnt), 64'(owner == 1));
      check_value({tag, "_dgnt"},  64'(bus.o_dcache_gnt), 64'(owner == 2));
      check_value({tag, "_mreq"},  64'(bus.o_mem_req),    64'd1);
      check_value({tag, "_addr"},  bus.o_mem_addr,         addr);
   endtask

   // One memory beat; owner 0 = nobody granted, 1 = icache, 2 = dcache
   task automatic beat(input logic last, input int owner);
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      bus.i_mem_r_valid = 1'b1;
      bus.i_mem_r_last  = last;
      bus.i_mem_r_data  = d;
      #1;
      check_value("ivalid", 64'(bus.o_icache_r_valid), 64'(owner == 1));
      check_value("ilast",  64'(bus.o_icache_r_last),  64'(owner == 1 && last));
      check_value("dvalid", 64'(bus.o_dcache_r_valid), 64'(owner == 2));
      check_value("dlast",  64'(bus.o_dcache_r_last),  64'(owner == 2 && last));
      check_value("rdata",  64'(bus.o_r_data),         64'(d));
      check_value("bmreq",  64'(bus.o_mem_req),        64'(owner != 0));
      if (bus.o_icache_r_last) ilast_seen++;
      if (bus.o_dcache_r_last) dlast_seen++;
      @(posedge clk);
      #1;
      bus.i_mem_r_valid = 1'b0;
      bus.i_mem_r_last  = 1'b0;
   endtask

   task automatic burst(input int n, input int last_at, input int owner);
      for (int i = 1; i <= n; i++) beat(i == last_at, owner);
   endtask

   task automatic pulse_reset();
      arst = 1'b1;
      #3;
      arst = 1'b0;
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      ilast_seen = 0;
      dlast_seen = 0;
      arst = 1'b1;
      bus.i_icache_req  = 1'b0;
      bus.i_icache_addr = '0;
      bus.i_dcache_req  = 1'b0;
      bus.i_dcache_addr = '0;
      bus.i_mem_r_valid = 1'b0;
      bus.i_mem_r_last  = 1'b0;
      bus.i_mem_r_data  = '0;
      #12;
      check_idle("rst");
      check_value("rst_addr", bus.o_mem_addr, 64'd0);
      check_value("rst_err", 64'(bus.o_burst_err), 64'd0);
      #4 arst = 1'b0;
      step();

      // Single icache burst, request dropped mid-burst
      bus.i_icache_req  = 1'b1;
      bus.i_icache_addr = 64'h1000;
      #1;
      check_value("pre_gnt", 64'(bus.o_icache_gnt), 64'd0);
      step();
      check_grant("i1", 1, 64'h1000);
      burst(2, 0, 1);
      bus.i_icache_req = 1'b0;
      ilast_seen = 0;
      burst(14, 14, 1);
      check_value("i1_lastcnt", 64'(ilast_seen), 64'd1);
      check_idle("i1_end");
      check_value("i1_err", 64'(bus.o_burst_err), 64'd0);

      // Tie from reset: dcache first
      pulse_reset();
      bus.i_icache_req  = 1'b1;
      bus.i_icache_addr = 64'h2000;
      bus.i_dcache_req  = 1'b1;
      bus.i_dcache_addr = 64'h3000;
      step();
      check_grant("tie1", 2, 64'h3000);
      burst(16, 16, 2);
      check_idle("tie_gap");
      step();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check_grant("tie2", 1, 64'h2000);
      burst(16, 16, 1);
`else
      check_grant("tie2", 2, 64'h3000);
      burst(16, 16, 2);
`endif
      bus.i_dcache_req = 1'b0;
      step();
      check_grant("tie3", 1, 64'h2000);
      bus.i_icache_req = 1'b0;
      burst(16, 16, 1);
      check_idle("tie_end");

      // icache arrives mid dcache burst
      bus.i_dcache_req  = 1'b1;
      bus.i_dcache_addr = 64'h4000;
      step();
      check_grant("mid_d", 2, 64'h4000);
      burst(3, 0, 2);
      bus.i_icache_req  = 1'b1;
      bus.i_icache_addr = 64'h5000;
      bus.i_dcache_req  = 1'b0;
      #1;
      check_value("mid_nogi", 64'(bus.o_icache_gnt), 64'd0);
      burst(13, 13, 2);
      check_idle("mid_gap");
      step();
      check_grant("mid_i", 1, 64'h5000);
      bus.i_icache_req = 1'b0;
      burst(16, 16, 1);
      check_value("mid_err", 64'(bus.o_burst_err), 64'd0);

      // Short burst raises sticky error
      bus.i_icache_req = 1'b1;
      step();
      bus.i_icache_req = 1'b0;
      burst(8, 8, 1);
      check_idle("short_end");
      check_value("short_err", 64'(bus.o_burst_err), 64'd1);
      bus.i_dcache_req = 1'b1;
      step();
      bus.i_dcache_req = 1'b0;
      burst(16, 16, 2);
      check_value("sticky_err", 64'(bus.o_burst_err), 64'd1);

      // Reset mid icache burst, request held
      pulse_reset();
      check_value("clr_err", 64'(bus.o_burst_err), 64'd0);
      bus.i_icache_req  = 1'b1;
      bus.i_icache_addr = 64'h6000;
      step();
      check_grant("ab1", 1, 64'h6000);
      burst(4, 0, 1);
      bus.i_mem_r_valid = 1'b1;
      #2;
      arst = 1'b1;
      #1;
      check_idle("ab_rst");
      check_value("ab_addr",   bus.o_mem_addr, 64'd0);
      check_value("ab_ivalid", 64'(bus.o_icache_r_valid), 64'd0);
      @(posedge clk);
      #1;
      arst = 1'b0;
      bus.i_mem_r_valid = 1'b0;
      step();
      check_grant("ab2", 1, 64'h6000);
      bus.i_icache_req = 1'b0;
      burst(16, 16, 1);
      check_value("ab_err", 64'(bus.o_burst_err), 64'd0);

      // Stray beats while idle
      burst(3, 2, 0);
      check_idle("stray");
      check_value("stray_err", 64'(bus.o_burst_err), 64'd0);
      bus.i_dcache_req = 1'b1;
      step();
      bus.i_dcache_req = 1'b0;
      burst(16, 16, 2);
      check_value("stray_cnt_err", 64'(bus.o_burst_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, address width.
REQ-002 Parameter DATA_W, default 32, read-beat data width.
REQ-003 Parameter BEATS, default 16, beats per cache-block refill burst (power of two, >=2).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 arst  in  1  asynchronous, active-high reset.
REQ-006 i_icache_req  in  1  instruction-cache refill request, level, held through its burst.
REQ-007 i_icache_addr  in  ADDR_W  instruction-cache block address.
REQ-008 i_dcache_req  in  1  data-cache refill request, level, held through its burst.
REQ-009 i_dcache_addr  in  ADDR_W  data-cache block address.
REQ-010 o_icache_gnt / o_dcache_gnt  out  1 each  requester owns the memory read port.
REQ-011 o_icache_r_valid, o_icache_r_last / o_dcache_r_valid, o_dcache_r_last  out  1 each  routed beat strobes.
REQ-012 o_r_data  out  DATA_W  shared beat data, i_mem_r_data passed through combinationally.
REQ-013 o_mem_req  out  1  burst read request to memory, level.
REQ-014 o_mem_addr  out  ADDR_W  registered burst address.
REQ-015 i_mem_r_valid, i_mem_r_last  in  1 each  memory beat valid / final beat.
REQ-016 i_mem_r_data  in  DATA_W  memory beat data.
REQ-017 o_burst_err  out  1  sticky burst-length error flag.

Function
REQ-018 FSM states: IDLE, GRANT_I, GRANT_D.
REQ-019 IDLE: no request -> stay; request(s) -> GRANT_I or GRANT_D next cycle per REQ-024, latching the winner's address into o_mem_addr on that edge.
REQ-020 GRANT_x: o_x_gnt=1, o_mem_req=1; other grant, o_mem_req to the loser and loser strobes stay 0.
REQ-021 GRANT_x: o_x_r_valid = i_mem_r_valid, o_x_r_last = i_mem_r_valid & i_mem_r_last; non-owner strobes 0.
REQ-022 GRANT_x: i_mem_r_valid & i_mem_r_last -> IDLE; at least one IDLE cycle always separates bursts.
REQ-023 Grant is locked for the whole burst; owner deasserting its request mid-burst is ignored and the burst completes.
REQ-024 Single requester in IDLE wins; tie broken per Configuration.
REQ-025 Beat counter, log2(BEATS) bits, cleared on entry to GRANT_x, increments on each i_mem_r_valid, wraps.
REQ-026 o_burst_err set when i_mem_r_last arrives with counter != BEATS-1, or when the beat with counter == BEATS-1 arrives without i_mem_r_last; sticky until reset; FSM behaviour unaffected.
REQ-027 i_mem_r_valid in IDLE: ignored, no strobes, counter unchanged.
REQ-028 Latency: request to o_mem_req is exactly 1 cycle; beat to routed strobe is 0 cycles.

Reset
REQ-029 arst asynchronously forces IDLE, both grants 0, o_mem_req 0, o_mem_addr 0, counter 0, o_burst_err 0, round-robin pointer to "icache served last".
REQ-030 arst during a burst aborts it; after release the arbiter re-arbitrates from IDLE.

Configuration
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN defined: ties go to the requester not served last; pointer updates on each GRANT_x entry.
REQ-032 Macro undefined: fixed priority, dcache always wins ties; no pointer register.

Verification
REQ-033 Reset, then icache_req=1 addr 0x1000 -> next cycle o_icache_gnt=1, o_mem_req=1, o_mem_addr=0x1000; 16 beats, last on beat 16 -> o_icache_r_last once, IDLE after, o_burst_err=0.
REQ-034 Both requests same cycle from reset -> dcache granted first; after its burst plus one IDLE cycle, icache granted (RR) / dcache again if still requesting (fixed priority).
REQ-035 dcache burst in progress, icache_req asserted at beat 3 -> no icache strobes or grant until dcache r_last; icache granted one cycle after IDLE.
REQ-036 r_last on beat 8 with BEATS=16 -> o_burst_err=1 and stays 1 through later clean bursts until arst.
REQ-037 arst pulsed at beat 5 of icache burst -> all outputs 0 immediately; after release with icache_req held -> fresh grant, counter restarts at 0.
REQ-038 i_mem_r_valid pulses in IDLE -> no routed strobes, no error.
